fetch_unit: RTL and testbench

//   Instruction fetch stage of the RV32I core, directly upstream of the decoder.

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory and
// buffers returned words in order for decode, with full flush on branch/jump redirects.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 9,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_out,
    output logic [XLEN-1:0]       inst_pc,
    output logic [XLEN-1:0]       inst_pc_plus4,
    output logic                  misalign_err
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = CW1'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   tag_wr_q, tag_rd_q;
    logic [PW-1:0]   fifo_wr_q, fifo_rd_q;

    logic [XLEN-1:0] tag_pc     [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];

    logic            redirect_act;
    logic            redirect_aligned;
    logic            accept;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Every in-flight request and every buffered word holds a slot, so a response
    // always has room in the FIFO when it returns.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        redirect_act   = 1'b0;
        case (state_q)
            ST_RUN: begin
                redirect_act   = redirect_valid;
                imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_W);
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign redirect_aligned = redirect_act && (redirect_pc[1:0] == 2'b00);
    assign accept           = imem_req_valid && imem_req_ready;
    assign rsp_fire         = imem_rsp_valid && (inflight_q != '0);
    assign push             = rsp_fire && (drop_q == '0) && !redirect_act;
    assign pop              = inst_valid && inst_ready;

    // A redirect turns every request still outstanding (minus one returning now,
    // which is thrown away immediately) into a response to be discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(accept) - CW'(rsp_fire);

            if (redirect_aligned) begin
                pc_q <= redirect_pc;
            end else if (accept) begin
                pc_q <= pc_q + XLEN'(4);
            end

            if (redirect_act) begin
                drop_q <= inflight_q - CW'(rsp_fire);
            end else if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - 1'b1;
            end

            if (redirect_act) begin
                count_q   <= '0;
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) begin
                    fifo_wr_q <= ptr_inc(fifo_wr_q);
                end
                if (pop) begin
                    fifo_rd_q <= ptr_inc(fifo_rd_q);
                end
            end
        end
    end

    // The tag queue runs in lockstep with imem: one entry per accepted request,
    // retired by its response whether that response is kept or discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_pc[i]     <= '0;
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            if (accept) begin
                tag_pc[tag_wr_q] <= pc_q;
                tag_wr_q         <= ptr_inc(tag_wr_q);
            end
            if (rsp_fire) begin
                tag_rd_q <= ptr_inc(tag_rd_q);
            end
            if (push) begin
                fifo_instr[fifo_wr_q] <= imem_rdata;
                fifo_pc[fifo_wr_q]    <= tag_pc[tag_rd_q];
            end
        end
    end

    assign imem_addr     = pc_q[ADDR_WIDTH+1:2];
    assign inst_valid    = (count_q != '0);
    assign inst_out      = inst_valid ? fifo_instr[fifo_rd_q] : '0;
    assign inst_pc       = inst_valid ? fifo_pc[fifo_rd_q] : '0;
    assign inst_pc_plus4 = inst_valid ? (fifo_pc[fifo_rd_q] + XLEN'(4)) : '0;
    assign misalign_err  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable imem responder and a queue of
// expected PCs that is compared against every decode handshake.
module tb_fetch_unit;

    localparam int XLEN = 32;
    localparam int AW   = 9;

    logic            clk;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [AW-1:0]   imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_out;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_pc_plus4;
    logic            misalign_err;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    pend_t           pend_q[$];
    logic [XLEN-1:0] exp_q[$];
    int              lat;
    int              cyc;
    int              n_tests;
    int              n_fail;

    fetch_unit #(
        .XLEN      (XLEN),
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_pc_plus4 (inst_pc_plus4),
        .misalign_err  (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: word at address a is {16'hC0DE, 7'd0, a}, returned in order
    // lat cycles after acceptance; reset discards anything pending.
    initial begin
        cyc            = 0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                pend_q.delete();
            end else if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                pend_q.push_back('{imem_addr, cyc + lat});
            end
            @(posedge clk);
            #2;
            cyc++;
            if (rst !== 1'b1 && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = {16'hC0DE, 7'd0, pend_q[0].addr};
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rdata     = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic mem_rdy, input logic dec_rdy,
                                 input logic redir, input logic [XLEN-1:0] target);
        imem_req_ready = mem_rdy;
        inst_ready     = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = target;
    endtask

    task automatic checkOutput();
        logic [XLEN-1:0] exp_pc;
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL unexpected_word: observed pc %h expected no delivery", inst_pc);
            end
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("deliver_pc", inst_pc, exp_pc);
                check("deliver_instr", inst_out, {16'hC0DE, 7'd0, exp_pc[10:2]});
                check("deliver_pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            to_sample();
            to_drive();
        end
    endtask

    task automatic push_seq(input logic [XLEN-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + XLEN'(4 * i));
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 64;
        while (exp_q.size() != 0 && budget > 0) begin
            inst_ready = 1'b1;
            to_sample();
            to_drive();
            budget--;
        end
        inst_ready = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        lat     = 1;
        rst     = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        cycles(2);

        to_sample();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc_plus4", inst_pc_plus4, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        to_drive();

        // Streaming fetch from reset
        rst = 1'b0;
        push_seq(32'h0, 6);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        to_sample();
        check("a_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("a_first_addr", 32'(imem_addr), 32'd0);
        check("a_first_inst_valid", 32'(inst_valid), 32'd0);
        to_drive();
        to_sample();
        check("a_fill_inst_valid", 32'(inst_valid), 32'd0);
        to_drive();
        to_sample();
        check("a_first_word_valid", 32'(inst_valid), 32'd1);
        to_drive();
        drain("a_stream");

        // Decode stall: FIFO fills and fetching stops
        inst_ready = 1'b0;
        cycles(5);
        to_sample();
        check("b_full_req_valid", 32'(imem_req_valid), 32'd0);
        check("b_head_valid", 32'(inst_valid), 32'd1);
        check("b_head_pc", inst_pc, 32'd24);
        to_drive();
        push_seq(32'd24, 6);
        drain("b_resume");

        // imem not ready: address held stable
        cycles(4);
        imem_req_ready = 1'b0;
        push_seq(32'd48, 2);
        drain("c_pre");
        to_sample();
        check("c_hold_req_valid", 32'(imem_req_valid), 32'd1);
        check("c_hold_addr", 32'(imem_addr), 32'd14);
        to_drive();
        cycles(2);
        to_sample();
        check("c_hold_req_valid_later", 32'(imem_req_valid), 32'd1);
        check("c_hold_addr_later", 32'(imem_addr), 32'd14);
        to_drive();
        imem_req_ready = 1'b1;
        push_seq(32'd56, 3);
        drain("c_release");

        // Redirect with two requests in flight
        cycles(4);
        lat = 4;
        push_seq(32'd68, 2);
        drain("d_pre");
        to_sample();
        check("d_second_req_valid", 32'(imem_req_valid), 32'd1);
        check("d_second_addr", 32'(imem_addr), 32'd20);
        to_drive();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        lat = 1;
        to_sample();
        check("d_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        to_drive();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        to_sample();
        check("d_post_inst_valid", 32'(inst_valid), 32'd0);
        check("d_post_addr", 32'(imem_addr), 32'h40);
        check("d_post_req_valid", 32'(imem_req_valid), 32'd0);
        to_drive();
        push_seq(32'h100, 2);
        drain("d_target");

        // Redirect coinciding with a response and a decode handshake
        cycles(4);
        push_seq(32'h108, 2);
        inst_ready = 1'b1;
        to_sample();
        to_drive();
        inst_ready = 1'b0;
        to_sample();
        check("e_req_valid", 32'(imem_req_valid), 32'd1);
        check("e_req_addr", 32'(imem_addr), 32'h44);
        to_drive();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        to_sample();
        check("e_hs_inst_valid", 32'(inst_valid), 32'd1);
        check("e_hs_req_valid", 32'(imem_req_valid), 32'd0);
        to_drive();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        check("e_consumed_once", 32'(exp_q.size()), 32'd0);
        push_seq(32'h200, 2);
        drain("e_target");

        // Word-address wrap at the top of imem
        cycles(4);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h7FC);
        to_sample();
        to_drive();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        to_sample();
        check("f_top_req_valid", 32'(imem_req_valid), 32'd1);
        check("f_top_addr", 32'(imem_addr), 32'h1FF);
        to_drive();
        to_sample();
        check("f_wrap_req_valid", 32'(imem_req_valid), 32'd1);
        check("f_wrap_addr", 32'(imem_addr), 32'h000);
        to_drive();
        push_seq(32'h7FC, 3);
        drain("f_wrap");

        // Misaligned redirect
        cycles(4);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h102);
        to_sample();
        check("g_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        check("g_err_not_yet", 32'(misalign_err), 32'd0);
        to_drive();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        to_sample();
        check("g_err_set", 32'(misalign_err), 32'd1);
        check("g_err_req_valid", 32'(imem_req_valid), 32'd0);
        check("g_err_inst_valid", 32'(inst_valid), 32'd0);
        to_drive();
        cycles(5);
        to_sample();
        check("g_err_sticky", 32'(misalign_err), 32'd1);
        check("g_err_req_blocked", 32'(imem_req_valid), 32'd0);
        to_drive();
        inst_ready = 1'b0;

        // Reset clears the error, then reset again mid-fill
        rst = 1'b1;
        to_sample();
        check("h_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("h_rst_addr", 32'(imem_addr), 32'd0);
        check("h_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("h_rst_inst_out", inst_out, 32'd0);
        check("h_rst_inst_pc", inst_pc, 32'd0);
        check("h_rst_pc_plus4", inst_pc_plus4, 32'd0);
        check("h_rst_misalign", 32'(misalign_err), 32'd0);
        to_drive();
        rst = 1'b0;
        to_sample();
        check("h_restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("h_restart_addr", 32'(imem_addr), 32'd0);
        to_drive();
        cycles(1);
        rst = 1'b1;
        to_sample();
        check("h_mid_inst_valid", 32'(inst_valid), 32'd0);
        check("h_mid_req_valid", 32'(imem_req_valid), 32'd0);
        check("h_mid_misalign", 32'(misalign_err), 32'd0);
        to_drive();
        rst = 1'b0;
        push_seq(32'h0, 3);
        inst_ready = 1'b1;
        to_sample();
        check("h_again_req_valid", 32'(imem_req_valid), 32'd1);
        check("h_again_addr", 32'(imem_addr), 32'd0);
        to_drive();
        drain("h_restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
